// File: rtl/fetch_pc_unit_pkg.sv
// Shared definitions for the F-stage PC unit: PCSel codes, reset PC,
// FSM state encodings and the fetch-address legality helper.
package fetch_pc_unit_pkg;

  // D-stage controller PC source encoding
  typedef enum logic [1:0] {
    PCSEL_ADD4 = 2'd0,
    PCSEL_NPC  = 2'd1,
    PCSEL_JRPC = 2'd2
  } pcsel_e;

  // Fetch FSM states
  typedef enum logic [1:0] {
    S_BOOT  = 2'd0,
    S_RUN   = 2'd1,
    S_FAULT = 2'd2
  } state_e;

  localparam logic [31:0] PC_RESET_DEF = 32'h0000_3000;
  localparam int          IM_WORDS_DEF = 1024;

  // A fetch address is legal when word aligned and inside the IM window.
  function automatic logic pc_in_range(input logic [31:0] pc,
                                       input logic [31:0] base,
                                       input int          words);
    logic [31:0] last;
    last = base + 32'(words * 4) - 32'd4;
    return (pc[1:0] == 2'b00) && (pc >= base) && (pc <= last);
  endfunction

endpackage

// File: rtl/fetch_pc_unit_npc_calc.sv
// Next-PC calculator: turns the D-stage control (PCSel/isj/isb) and the
// D-stage instruction fields into a redirect request and its target.
// Purely combinational; stall qualification is done by the caller.
module npc_calc
  import fetch_pc_unit_pkg::*;
(
  input  logic [1:0]  PCSel,
  input  logic        isj,
  input  logic        isb,
  input  logic [31:0] IR_D,
  input  logic [31:0] PC_D,
  input  logic [31:0] rs_fwd,
  output logic        redirect,
  output logic [31:0] target
);

  logic [31:0] w_pc_d_plus4;
  logic [31:0] w_br_offset;
  logic [31:0] w_br_target;
  logic [31:0] w_j_target;
  logic        w_unused_opcode;

  assign w_pc_d_plus4    = PC_D + 32'd4;
  assign w_br_offset     = {{14{IR_D[15]}}, IR_D[15:0], 2'b00};
  assign w_br_target     = w_pc_d_plus4 + w_br_offset;
  assign w_j_target      = {PC_D[31:28], IR_D[25:0], 2'b00};
  // Opcode bits are decoded upstream; only the immediate fields matter here.
  assign w_unused_opcode = ^IR_D[31:26];

  // Select redirect and target; an untaken branch (NPC with isj=isb=0) is no redirect.
  always_comb begin
    redirect = 1'b0;
    target   = w_pc_d_plus4;
    case (PCSel)
      PCSEL_NPC: begin
        if (isj) begin
          redirect = 1'b1;
          target   = w_j_target;
        end else if (isb) begin
          redirect = 1'b1;
          target   = w_br_target;
        end
      end
      PCSEL_JRPC: begin
        redirect = 1'b1;
        target   = rs_fwd;
      end
      default: begin
        redirect = 1'b0;
        target   = w_pc_d_plus4;
      end
    endcase
  end

endmodule

// File: rtl/fetch_pc_unit.sv
// F-stage PC/NPC unit: owns the PC register, the instruction-memory
// req/ready handshake and the F/D instruction register.
// D-stage redirects honour the MIPS delay slot: the target is applied only
// once the delay-slot fetch (pc = PC_D+4) has been accepted; until then it
// is parked in a pending register (latest redirect wins).
// Optional feature: FETCH_ALIGN_CHECK_EN enables fetch-address fault
// detection (misaligned or outside IM) with a sticky S_FAULT state.
module fetch_pc_unit
  import fetch_pc_unit_pkg::*;
#(
  parameter logic [31:0] PC_RESET = PC_RESET_DEF,
  parameter int          IM_WORDS = IM_WORDS_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall_i,
  input  logic [1:0]  PCSel,
  input  logic        isj,
  input  logic        isb,
  input  logic [31:0] IR_D,
  input  logic [31:0] PC_D,
  input  logic [31:0] rs_fwd,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] IR_F,
  output logic [31:0] PC_F,
  output logic        valid_F,
  output logic        exc_adel
);

  state_e      r_state;
  state_e      w_state_nxt;
  logic [31:0] r_pc;
  logic        r_pend;
  logic [31:0] r_pend_tgt;
  logic [31:0] r_ir;
  logic [31:0] r_pc_f;
  logic        r_valid;

  logic        w_redirect_raw;
  logic        w_redirect;
  logic [31:0] w_target;
  logic        w_accept;
  logic [31:0] w_pc_seq;
  logic [31:0] w_pc_new;
  logic        w_pc_ok;
  logic        w_fault;

  npc_calc u_npc_calc (
    .PCSel    (PCSel),
    .isj      (isj),
    .isb      (isb),
    .IR_D     (IR_D),
    .PC_D     (PC_D),
    .rs_fwd   (rs_fwd),
    .redirect (w_redirect_raw),
    .target   (w_target)
  );

  assign w_redirect = ~stall_i & w_redirect_raw;
  assign w_accept   = imem_req & imem_ready;
  assign w_pc_seq   = r_pc + 32'd4;
  assign w_pc_new   = w_redirect ? w_target : (r_pend ? r_pend_tgt : w_pc_seq);
  assign w_pc_ok    = pc_in_range(w_pc_new, PC_RESET, IM_WORDS);

`ifdef FETCH_ALIGN_CHECK_EN
  logic r_exc;

  // A bad next PC is never fetched: it raises the fault on the accepting edge.
  assign w_fault   = w_accept & ~w_pc_ok;
  assign imem_addr = r_pc;
  assign exc_adel  = r_exc;

  // Sticky address-error flag, cleared only by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_exc <= 1'b0;
    end else if (w_fault) begin
      r_exc <= 1'b1;
    end
  end
`else
  logic w_unused_range;

  assign w_fault        = 1'b0;
  assign w_unused_range = w_pc_ok;
  assign imem_addr      = {r_pc[31:2], 2'b00};
  assign exc_adel       = 1'b0;
`endif

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_BOOT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next state: boot lasts one cycle; fault is sticky until reset.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_BOOT:  w_state_nxt = S_RUN;
      S_RUN:   w_state_nxt = w_fault ? S_FAULT : S_RUN;
      S_FAULT: w_state_nxt = S_FAULT;
      default: w_state_nxt = S_BOOT;
    endcase
  end

  // FSM outputs: fetch only while running, unstalled and out of reset.
  always_comb begin
    imem_req = 1'b0;
    if (r_state == S_RUN) begin
      imem_req = ~stall_i & ~reset;
    end
  end

  // PC, pending redirect and F/D register update.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc       <= PC_RESET;
      r_pend     <= 1'b0;
      r_pend_tgt <= 32'd0;
      r_ir       <= 32'd0;
      r_pc_f     <= 32'd0;
      r_valid    <= 1'b0;
    end else if (!stall_i) begin
      if (w_accept) begin
        r_ir    <= imem_rdata;
        r_pc_f  <= r_pc;
        r_valid <= 1'b1;
        r_pc    <= w_pc_new;
        r_pend  <= 1'b0;
      end else begin
        r_ir    <= 32'd0;
        r_valid <= 1'b0;
        if (w_redirect) begin
          r_pend     <= 1'b1;
          r_pend_tgt <= w_target;
        end
      end
    end
  end

  assign IR_F    = r_ir;
  assign PC_F    = r_pc_f;
  assign valid_F = r_valid;

endmodule

// File: tb/tb_fetch_pc_unit.sv
module tb_fetch_pc_unit;

  localparam logic [31:0] PC_LO = 32'h0000_3000;
  localparam logic [31:0] PC_HI = 32'h0000_3FFC;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall_i;
  logic [1:0]  PCSel;
  logic        isj;
  logic        isb;
  logic [31:0] IR_D;
  logic [31:0] PC_D;
  logic [31:0] rs_fwd;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] IR_F;
  logic [31:0] PC_F;
  logic        valid_F;
  logic        exc_adel;

  int n_cmp = 0;
  int n_bad = 0;

  // reference model: 0 = boot, 1 = running, 2 = faulted
  int          m_state = 0;
  logic [31:0] m_pc    = PC_LO;
  logic [31:0] m_tgt   = 32'd0;
  logic [31:0] m_ir    = 32'd0;
  logic [31:0] m_pcf   = 32'd0;
  logic        m_pend  = 1'b0;
  logic        m_valid = 1'b0;
  logic        m_exc   = 1'b0;

  always #5 clk = ~clk;

  fetch_pc_unit dut (
    .clk        (clk),
    .reset      (reset),
    .stall_i    (stall_i),
    .PCSel      (PCSel),
    .isj        (isj),
    .isb        (isb),
    .IR_D       (IR_D),
    .PC_D       (PC_D),
    .rs_fwd     (rs_fwd),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ready (imem_ready),
    .imem_rdata (imem_rdata),
    .IR_F       (IR_F),
    .PC_F       (PC_F),
    .valid_F    (valid_F),
    .exc_adel   (exc_adel)
  );

  function automatic logic exp_req();
    return (m_state == 1) && !stall_i && !reset;
  endfunction

  function automatic logic [31:0] exp_addr();
`ifdef FETCH_ALIGN_CHECK_EN
    return m_pc;
`else
    return m_pc & 32'hFFFF_FFFC;
`endif
  endfunction

  // Advance the model by one clock using the inputs currently driven, then clock the DUT.
  task automatic step();
    int          n_state;
    logic [31:0] n_pc, n_tgt, n_ir, n_pcf, tgt;
    logic        n_pend, n_valid, n_exc, acc, red;
    n_state = m_state; n_pc = m_pc; n_tgt = m_tgt; n_ir = m_ir; n_pcf = m_pcf;
    n_pend = m_pend; n_valid = m_valid; n_exc = m_exc;
    if (reset) begin
      n_state = 0; n_pc = PC_LO; n_tgt = 0; n_ir = 0; n_pcf = 0;
      n_pend = 0; n_valid = 0; n_exc = 0;
    end else begin
      acc = exp_req() && imem_ready;
      red = !stall_i && ((PCSel == 2'd1 && (isj || isb)) || PCSel == 2'd2);
      if (PCSel == 2'd2)
        tgt = rs_fwd;
      else if (isj)
        tgt = (PC_D & 32'hF000_0000) | ((IR_D & 32'h03FF_FFFF) * 4);
      else
        tgt = PC_D + 32'd4 + 32'($signed(IR_D[15:0])) * 4;
      if (m_state == 0) n_state = 1;
      if (!stall_i) begin
        if (acc) begin
          n_ir = imem_rdata; n_pcf = m_pc; n_valid = 1'b1; n_pend = 1'b0;
          n_pc = red ? tgt : (m_pend ? m_tgt : m_pc + 32'd4);
`ifdef FETCH_ALIGN_CHECK_EN
          if (n_pc % 4 != 0 || n_pc < PC_LO || n_pc > PC_HI) begin
            n_exc = 1'b1; n_state = 2;
          end
`endif
        end else begin
          n_ir = 0; n_valid = 1'b0;
          if (red) begin n_pend = 1'b1; n_tgt = tgt; end
        end
      end
    end
    @(posedge clk);
    #1;
    m_state = n_state; m_pc = n_pc; m_tgt = n_tgt; m_ir = n_ir; m_pcf = n_pcf;
    m_pend = n_pend; m_valid = n_valid; m_exc = n_exc;
  endtask

  task automatic clear_ctl();
    PCSel = 2'd0; isj = 1'b0; isb = 1'b0; IR_D = 32'd0; PC_D = 32'd0; rs_fwd = 32'd0;
  endtask

  task automatic do_reset();
    reset = 1'b1; stall_i = 1'b0; imem_ready = 1'b0; clear_ctl();
    step(); step();
    reset = 1'b0;
    step();
  endtask

  task automatic fetch2();
    imem_ready = 1'b1;
    imem_rdata = 32'hAAAA_0001; step();
    imem_rdata = 32'hAAAA_0002; step();
  endtask

  task automatic test_reset();
    reset = 1'b1; stall_i = 1'b0; imem_ready = 1'b1; imem_rdata = 32'h1234_5678; clear_ctl();
    for (int i = 0; i < 2; i++) begin
      #1;
      n_cmp++; if (imem_req !== 1'b0) begin n_bad++; $display("FAIL reset_req[%0d]: got %b want 0", i, imem_req); end
      step();
    end
    n_cmp++; if (valid_F !== 1'b0 || IR_F !== 32'd0 || PC_F !== 32'd0) begin n_bad++;
      $display("FAIL reset_fd: valid=%b IR=%h PC=%h want 0/0/0", valid_F, IR_F, PC_F); end
    n_cmp++; if (exc_adel !== 1'b0) begin n_bad++; $display("FAIL reset_exc: got %b want 0", exc_adel); end
    n_cmp++; if (imem_addr !== 32'h3000) begin n_bad++; $display("FAIL reset_addr: got %h want 00003000", imem_addr); end
    reset = 1'b0; #1;
    n_cmp++; if (imem_req !== 1'b0 || valid_F !== 1'b0) begin n_bad++;
      $display("FAIL boot_req: req=%b valid=%b want 0/0", imem_req, valid_F); end
    step();
    n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 32'h3000 || valid_F !== 1'b0) begin n_bad++;
      $display("FAIL first_fetch: req=%b addr=%h valid=%b want 1/00003000/0", imem_req, imem_addr, valid_F); end
  endtask

  task automatic test_sequential();
    logic [31:0] d;
    imem_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      d = $urandom;
      imem_rdata = d; #1;
      n_cmp++; if (imem_addr !== PC_LO + 32'(4 * i) || imem_req !== 1'b1) begin n_bad++;
        $display("FAIL seq_addr[%0d]: got %h req=%b want %h req=1", i, imem_addr, imem_req, PC_LO + 32'(4 * i)); end
      step();
      n_cmp++; if (IR_F !== d || PC_F !== PC_LO + 32'(4 * i) || valid_F !== 1'b1) begin n_bad++;
        $display("FAIL seq_fd[%0d]: IR=%h PC=%h v=%b want %h %h 1", i, IR_F, PC_F, valid_F, d, PC_LO + 32'(4 * i)); end
    end
  endtask

  task automatic test_beq();
    do_reset(); fetch2();
    PCSel = 2'd1; isb = 1'b1; IR_D = 32'h1000_0003; PC_D = 32'h3004; #1;
    n_cmp++; if (imem_addr !== 32'h3008 || imem_req !== 1'b1) begin n_bad++;
      $display("FAIL beq_slot: addr=%h req=%b want 00003008 1", imem_addr, imem_req); end
    step(); clear_ctl(); #1;
    n_cmp++; if (imem_addr !== 32'h3014 || PC_F !== 32'h3008) begin n_bad++;
      $display("FAIL beq_target: addr=%h PC_F=%h want 00003014 00003008", imem_addr, PC_F); end
  endtask

  task automatic test_jal_pending();
    do_reset(); fetch2();
    imem_ready = 1'b0;
    PCSel = 2'd1; isj = 1'b1; IR_D = 32'h0C00_0C40; PC_D = 32'h3004;
    step(); clear_ctl(); #1;
    n_cmp++; if (imem_addr !== 32'h3008 || valid_F !== 1'b0 || imem_req !== 1'b1) begin n_bad++;
      $display("FAIL jal_hold1: addr=%h v=%b req=%b want 00003008 0 1", imem_addr, valid_F, imem_req); end
    step();
    n_cmp++; if (imem_addr !== 32'h3008) begin n_bad++; $display("FAIL jal_hold2: addr=%h want 00003008", imem_addr); end
    imem_ready = 1'b1; imem_rdata = 32'hDEAD_0008;
    step();
    n_cmp++; if (imem_addr !== 32'h3100 || PC_F !== 32'h3008 || IR_F !== 32'hDEAD_0008) begin n_bad++;
      $display("FAIL jal_target: addr=%h PC_F=%h IR=%h want 00003100 00003008 dead0008", imem_addr, PC_F, IR_F); end
  endtask

  task automatic test_jr_stall();
    logic [31:0] held;
    do_reset(); fetch2();
    held = IR_F;
    stall_i = 1'b1; PCSel = 2'd2; rs_fwd = 32'h3100; imem_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1;
      n_cmp++; if (imem_req !== 1'b0) begin n_bad++; $display("FAIL jr_stall_req[%0d]: got %b want 0", i, imem_req); end
      step();
      n_cmp++; if (IR_F !== held || imem_addr !== 32'h3008 || valid_F !== 1'b1) begin n_bad++;
        $display("FAIL jr_stall_hold[%0d]: IR=%h addr=%h v=%b want %h 00003008 1", i, IR_F, imem_addr, valid_F, held); end
    end
    stall_i = 1'b0; #1;
    n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 32'h3008) begin n_bad++;
      $display("FAIL jr_unstall: req=%b addr=%h want 1 00003008", imem_req, imem_addr); end
    step(); clear_ctl(); #1;
    n_cmp++; if (imem_addr !== 32'h3100 || PC_F !== 32'h3008) begin n_bad++;
      $display("FAIL jr_target: addr=%h PC_F=%h want 00003100 00003008", imem_addr, PC_F); end
  endtask

  task automatic test_jr_misaligned();
    do_reset(); fetch2();
    PCSel = 2'd2; rs_fwd = 32'h3102;
    step(); clear_ctl(); #1;
`ifdef FETCH_ALIGN_CHECK_EN
    for (int i = 0; i < 3; i++) begin
      n_cmp++; if (exc_adel !== 1'b1 || imem_req !== 1'b0) begin n_bad++;
        $display("FAIL adel_fault[%0d]: exc=%b req=%b want 1 0", i, exc_adel, imem_req); end
      step();
      n_cmp++; if (valid_F !== 1'b0) begin n_bad++; $display("FAIL adel_bubble[%0d]: v=%b want 0", i, valid_F); end
    end
`else
    n_cmp++; if (exc_adel !== 1'b0 || imem_addr !== 32'h3100 || imem_req !== 1'b1) begin n_bad++;
      $display("FAIL adel_off: exc=%b addr=%h req=%b want 0 00003100 1", exc_adel, imem_addr, imem_req); end
`endif
    do_reset();
    n_cmp++; if (exc_adel !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h3000) begin n_bad++;
      $display("FAIL adel_reset: exc=%b req=%b addr=%h want 0 1 00003000", exc_adel, imem_req, imem_addr); end
  endtask

  task automatic test_wrap();
    do_reset(); fetch2();
    PCSel = 2'd2;
`ifdef FETCH_ALIGN_CHECK_EN
    rs_fwd = 32'h0000_4000;
    step(); clear_ctl(); #1;
    n_cmp++; if (exc_adel !== 1'b1 || imem_req !== 1'b0) begin n_bad++;
      $display("FAIL range_fault: exc=%b req=%b want 1 0", exc_adel, imem_req); end
`else
    rs_fwd = 32'hFFFF_FFFC;
    step(); clear_ctl(); #1;
    n_cmp++; if (imem_addr !== 32'hFFFF_FFFC) begin n_bad++; $display("FAIL wrap_top: addr=%h want fffffffc", imem_addr); end
    step();
    n_cmp++; if (imem_addr !== 32'h0 || exc_adel !== 1'b0 || PC_F !== 32'hFFFF_FFFC) begin n_bad++;
      $display("FAIL wrap_zero: addr=%h exc=%b PC_F=%h want 00000000 0 fffffffc", imem_addr, exc_adel, PC_F); end
`endif
  endtask

  task automatic rand_inputs();
    int          k, k2, sel;
    logic [31:0] r;
    k = $urandom_range(0, 1023); k2 = $urandom_range(0, 1023); r = $urandom;
    reset      = ($urandom_range(0, 63) == 0);
    stall_i    = ($urandom_range(0, 4) == 0);
    imem_ready = ($urandom_range(0, 3) != 0);
    imem_rdata = $urandom;
    PC_D   = PC_LO + 32'(4 * k);
    IR_D   = r;
    rs_fwd = $urandom;
    PCSel  = 2'd0; isj = r[0]; isb = r[1];
    sel = $urandom_range(0, 6);
    case (sel)
      3: begin PCSel = 2'd1; isj = 1'b0; isb = 1'b0; end
      4: begin PCSel = 2'd1; isj = 1'b0; isb = 1'b1; IR_D = {r[31:16], 16'(k2 - k - 1)}; end
      5: begin PCSel = 2'd1; isj = 1'b1; isb = 1'b0; IR_D = {r[31:26], 26'(32'(PC_LO >> 2) + 32'(k2))}; end
      6: begin PCSel = 2'd2; isj = 1'b0; isb = 1'b0; rs_fwd = PC_LO + 32'(4 * k2); end
      default: PCSel = 2'd0;
    endcase
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      rand_inputs(); #1;
      n_cmp++; if (imem_req !== exp_req() || imem_addr !== exp_addr()) begin n_bad++;
        $display("FAIL rand_fetch[%0d]: req=%b addr=%h want %b %h", i, imem_req, imem_addr, exp_req(), exp_addr()); end
      n_cmp++; if (IR_F !== m_ir || PC_F !== m_pcf || valid_F !== m_valid) begin n_bad++;
        $display("FAIL rand_fd[%0d]: IR=%h PC=%h v=%b want %h %h %b", i, IR_F, PC_F, valid_F, m_ir, m_pcf, m_valid); end
      n_cmp++; if (exc_adel !== m_exc) begin n_bad++;
        $display("FAIL rand_exc[%0d]: got %b want %b", i, exc_adel, m_exc); end
      step();
    end
  endtask

  task automatic test_back_to_back();
    // two redirects while the delay slot waits: the later one must win
    do_reset(); fetch2();
    imem_ready = 1'b0;
    PCSel = 2'd2; rs_fwd = 32'h3200; step();
    rs_fwd = 32'h3300; step();
    clear_ctl(); imem_ready = 1'b1; step();
    n_cmp++; if (imem_addr !== 32'h3300 || PC_F !== 32'h3008) begin n_bad++;
      $display("FAIL latest_wins: addr=%h PC_F=%h want 00003300 00003008", imem_addr, PC_F); end
    step();
    n_cmp++; if (imem_addr !== 32'h3304 || PC_F !== 32'h3300) begin n_bad++;
      $display("FAIL pend_cleared: addr=%h PC_F=%h want 00003304 00003300", imem_addr, PC_F); end
  endtask

  initial begin
    reset = 1'b1; stall_i = 1'b0; imem_ready = 1'b0; imem_rdata = 32'd0;
    clear_ctl();
    test_reset();
    test_sequential();
    test_beq();
    test_jal_pending();
    test_jr_stall();
    test_back_to_back();
    test_wrap();
    test_jr_misaligned();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
